mono_fifo_arbiter: RTL and testbench
====================================

MONO_FIFO_ARBITER -- requirements
Module: mono_fifo_arbiter

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, range 2..8: number of upstream mono_data_rx FIFO ports merged.
REQ-002 SHALL have parameter MAX_BURST, default 16, range 1..255: maximum words taken from one port per grant.
REQ-003 SHALL have port BUS_CLK  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port BUS_RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port IN_EMPTY  input  N_INPUTS  per-port upstream FIFO empty flag.
REQ-006 SHALL have port IN_DATA  input  32*N_INPUTS  per-port first-word-fall-through data; port i occupies bits [32i+31:32i].
REQ-007 SHALL have port IN_READ  output  N_INPUTS  per-port pop strobe, one word per high cycle.
REQ-008 SHALL have port OUT_READ  input  1  downstream pop strobe.
REQ-009 SHALL have port OUT_EMPTY  output  1  merged output empty flag.
REQ-010 SHALL have port OUT_DATA  output  32  merged first-word-fall-through data, valid while OUT_EMPTY low.
REQ-011 SHALL have port GRANT  output  3  index of currently granted port.
REQ-012 SHALL have port BUSY  output  1  high when the state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ARB, XFER.
REQ-014 IDLE SHALL go to ARB on the cycle after any IN_EMPTY bit is low; IDLE otherwise.
REQ-015 ARB SHALL last exactly one cycle, searching ports GRANT+1, GRANT+2, ... modulo N_INPUTS, ending with GRANT itself, for the first non-empty port.
REQ-016 ARB SHALL load GRANT with the found index, clear the burst counter, and go to XFER; if none is found, GRANT SHALL hold and the state SHALL go to IDLE.
REQ-017 In XFER, IN_READ[GRANT] SHALL be high when IN_EMPTY[GRANT] is low and the output buffer has space; all other IN_READ bits SHALL be low in every state.
REQ-018 The output buffer SHALL hold 2 words; it has space when its count is below 2, or when the count is 2 and OUT_READ pops in the same cycle.
REQ-019 The word on IN_DATA[GRANT] during an IN_READ cycle SHALL be written into the output buffer at that clock edge.
REQ-020 Latency: with the buffer empty, the word SHALL appear on OUT_DATA with OUT_EMPTY low in the cycle after IN_READ.
REQ-021 Each IN_READ pulse SHALL increment the 8-bit burst counter.
REQ-022 XFER SHALL go to ARB when the counter reaches MAX_BURST, or when IN_EMPTY[GRANT] is high and no read occurs.
REQ-023 XFER SHALL stay in XFER while stalled by a full buffer and the counter is below MAX_BURST.
REQ-024 OUT_READ while OUT_EMPTY is high SHALL be ignored without changing any state.
REQ-025 A simultaneous buffer write and pop SHALL keep the buffer count unchanged while preserving word order.
REQ-026 Words SHALL be neither dropped nor duplicated.
REQ-027 Per-port word order SHALL be preserved; the merged stream is ordered by grant sequence.
REQ-028 Throughput SHALL be 1 word per cycle within a burst, with a 1-cycle ARB gap between bursts.

Reset
REQ-029 While BUS_RST is high, the module SHALL hold: state IDLE, GRANT = N_INPUTS-1 (so port 0 is searched first), burst counter 0, buffer count 0, OUT_EMPTY 1, OUT_DATA 0, IN_READ 0, BUSY 0.
REQ-030 Reset asserted mid-burst SHALL discard buffered words with no IN_READ pulse issued.
REQ-031 After reset release, the first ARB SHALL occur no earlier than the second clock edge.

Structure
REQ-032 Package mono_fifo_arbiter_pkg SHALL hold the state enum, the word width constant 32, and the buffer depth constant 2.
REQ-033 The 2-entry output buffer SHALL be the sub-module mono_fifo_arbiter_obuf, with push, pop, count, empty and data ports.

Verification
REQ-034 Single port: port 0 holds 3 words A0..A2; OUT_READ is held high. The bench SHALL see IN_READ[0] high on 3 consecutive cycles, OUT_DATA = A0, A1, A2 in order, then IDLE with BUSY low.
REQ-035 Burst limit: MAX_BURST=4; ports 0 and 1 each hold 10 words. The bench SHALL see the output sequence 4 words of port 0, 4 of port 1, 4 of port 0, and so on, each grant separated by exactly one ARB cycle.
REQ-036 Back-pressure: OUT_READ is held low; port 2 holds 5 words. The bench SHALL see exactly 2 IN_READ pulses and no further reads; OUT_READ then high yields all 5 words in order.
REQ-037 Wrap-around: GRANT=3 and ports 0 and 3 are both non-empty. The bench SHALL see ARB select port 0.
REQ-038 Simultaneous events: buffer count is 2 while OUT_READ and IN_READ are in the same cycle. The bench SHALL see the count stay 2 and order preserved.
REQ-039 Reset mid-burst: BUS_RST asserted during XFER with buffer count 1. The bench SHALL see all outputs at their reset values immediately, with no IN_READ pulse.

Source files
------------

// File: rtl/mono_fifo_arbiter_pkg.sv
// Shared definitions for the mono FIFO arbiter.
//   state_t     : arbiter FSM states
//   WORD_W      : data word width
//   OBUF_DEPTH  : depth of the merged output buffer
//   wrap_add    : (base + off) modulo n, for small n (off <= n, base < n)
package mono_fifo_arbiter_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  function automatic logic [2:0] wrap_add(input logic [2:0] base,
                                          input int unsigned off,
                                          input int unsigned n);
    int unsigned s;
    s = {29'd0, base} + off;
    if (s >= n) s = s - n;
    return s[2:0];
  endfunction

endpackage

// File: rtl/mono_fifo_arbiter_obuf.sv
// Two-entry first-word-fall-through output buffer.
//   clk, rst   : clock, async active-high reset
//   push       : write push_data this cycle (ignored when full without a pop)
//   push_data  : word to write
//   pop        : consume the head word (ignored when empty)
//   count      : number of stored words (0..2)
//   empty      : count == 0
//   data       : head word, valid while empty is low
module mono_fifo_arbiter_obuf
  import mono_fifo_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic              empty,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] mem [OBUF_DEPTH];
  logic              pop_ok;
  logic              push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count < 2'(OBUF_DEPTH)) || pop_ok);
  assign empty   = (count == 2'd0);
  assign data    = mem[0];

  // mem[0] is always the head; a pop shifts mem[1] down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) mem[0] <= push_data;
          else               mem[1] <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem[0] <= push_data;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mono_fifo_arbiter.sv
// Round-robin merger of N_INPUTS first-word-fall-through FIFO ports into a
// single FWFT output stream, taking up to MAX_BURST words per grant.
//   BUS_CLK, BUS_RST : clock, async active-high reset
//   IN_EMPTY/IN_DATA : per-port upstream empty flag and head word (32 bits each)
//   IN_READ          : per-port pop strobe, only the granted bit ever rises
//   OUT_READ         : downstream pop strobe
//   OUT_EMPTY/OUT_DATA : merged output flag and head word
//   GRANT            : currently granted port index
//   BUSY             : FSM is not IDLE
module mono_fifo_arbiter
  import mono_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       BUS_CLK,
  input  logic                       BUS_RST,
  input  logic [N_INPUTS-1:0]        IN_EMPTY,
  input  logic [WORD_W*N_INPUTS-1:0] IN_DATA,
  output logic [N_INPUTS-1:0]        IN_READ,
  input  logic                       OUT_READ,
  output logic                       OUT_EMPTY,
  output logic [WORD_W-1:0]          OUT_DATA,
  output logic [2:0]                 GRANT,
  output logic                       BUSY
);

  state_t            state, state_nx;
  logic [2:0]        grant_nx;
  logic [7:0]        burst_cnt, burst_nx;
  logic              grant_empty;
  logic [WORD_W-1:0] grant_data;
  logic              found;
  logic [2:0]        found_idx;
  logic [1:0]        ob_count;
  logic              space;
  logic              rd;

  // Granted-port mux.
  always_comb begin
    grant_empty = 1'b1;
    grant_data  = '0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      if (GRANT == 3'(i)) begin
        grant_empty = IN_EMPTY[i];
        grant_data  = IN_DATA[WORD_W*i +: WORD_W];
      end
    end
  end

  // Search GRANT+1 .. GRANT+N_INPUTS (mod N_INPUTS); the current grant is last.
  always_comb begin
    found     = 1'b0;
    found_idx = GRANT;
    for (int unsigned off = 1; off <= N_INPUTS; off++) begin
      for (int unsigned j = 0; j < N_INPUTS; j++) begin
        if (!found && !IN_EMPTY[j] && (3'(j) == wrap_add(GRANT, off, N_INPUTS))) begin
          found     = 1'b1;
          found_idx = 3'(j);
        end
      end
    end
  end

  // A full buffer still has room when the downstream pops in the same cycle.
  assign space = (ob_count < 2'(OBUF_DEPTH)) || OUT_READ;
  assign rd    = (state == XFER) && !grant_empty && space &&
                 (burst_cnt < 8'(MAX_BURST));

  always_comb begin
    IN_READ = '0;
    for (int unsigned j = 0; j < N_INPUTS; j++)
      IN_READ[j] = rd && (GRANT == 3'(j));
  end

  always_comb begin
    state_nx = state;
    grant_nx = GRANT;
    burst_nx = burst_cnt;
    case (state)
      IDLE: if (IN_EMPTY != '1) state_nx = ARB;
      ARB: begin
        if (found) begin
          grant_nx = found_idx;
          burst_nx = '0;
          state_nx = XFER;
        end else begin
          state_nx = IDLE;
        end
      end
      XFER: begin
        if (rd) burst_nx = burst_cnt + 8'd1;
        if (burst_nx == 8'(MAX_BURST))  state_nx = ARB;
        else if (!rd && grant_empty)    state_nx = ARB;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state     <= IDLE;
      GRANT     <= 3'(N_INPUTS - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      GRANT     <= grant_nx;
      burst_cnt <= burst_nx;
    end
  end

  assign BUSY = (state != IDLE);

  mono_fifo_arbiter_obuf u_obuf (
    .clk       (BUS_CLK),
    .rst       (BUS_RST),
    .push      (rd),
    .push_data (grant_data),
    .pop       (OUT_READ),
    .count     (ob_count),
    .empty     (OUT_EMPTY),
    .data      (OUT_DATA)
  );

endmodule

// File: tb/tb_mono_fifo_arbiter.sv
module tb_mono_fifo_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   in_empty;
  logic [32*NP-1:0] in_data;
  logic [NP-1:0]   in_read;
  logic            out_read;
  logic            out_empty;
  logic [31:0]     out_data;
  logic [2:0]      grant;
  logic            busy;

  mono_fifo_arbiter #(.N_INPUTS(NP), .MAX_BURST(MB)) dut (
    .BUS_CLK   (clk),
    .BUS_RST   (rst),
    .IN_EMPTY  (in_empty),
    .IN_DATA   (in_data),
    .IN_READ   (in_read),
    .OUT_READ  (out_read),
    .OUT_EMPTY (out_empty),
    .OUT_DATA  (out_data),
    .GRANT     (grant),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int nwords;
    int exp_grant;
    int exp_busy;
  } vec_t;

  logic [31:0] src_q [NP][$];
  logic [31:0] exp_q [$];
  int          ev_cyc [$];
  int          ev_port [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt = 0;
  logic [NP-1:0] rd_s;
  logic        busy_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      in_empty[i] = (src_q[i].size() == 0);
      in_data[32*i +: 32] = in_empty[i] ? (32'hBAD0_0000 | 32'(i)) : src_q[i][0];
    end
  endtask

  task automatic load(input int p, input int n);
    for (int k = 0; k < n; k++)
      src_q[p].push_back({4'(p), 12'(k), 16'($urandom)});
  endtask

  task automatic push_exp(input int p, input int from, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(src_q[p][from + k]);
  endtask

  // One clock cycle: sample at negedge, apply upstream pops just after posedge.
  task automatic step();
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    rd_s   = in_read;
    busy_s = busy;
    if (in_read != '0) chk("in_read_onehot", 32'(in_read), 32'd1 << grant);
    if (out_read && !out_empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", out_data);
      end else begin
        w = exp_q.pop_front();
        if (out_data !== w) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h", out_data, w);
        end
      end
    end
    for (int i = 0; i < NP; i++)
      if (in_read[i]) begin
        ev_cyc.push_back(cyc);
        ev_port.push_back(i);
        rd_cnt++;
      end
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (rd_s[i]) begin
        if (src_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_empty: port %0d got pop expected none", i);
        end else begin
          void'(src_q[i].pop_front());
        end
      end
    refresh();
  endtask

  task automatic run_to_idle(input int budget, output int busy_n);
    bit seen;
    seen   = 1'b0;
    busy_n = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (busy_s) begin
        seen = 1'b1;
        busy_n++;
      end else if (seen) begin
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got busy after %0d cycles expected idle", budget);
  endtask

  task automatic clear_ev();
    ev_cyc.delete();
    ev_port.delete();
    rd_cnt = 0;
  endtask

  initial begin
    vec_t vecs [4];
    int   bn;
    int   k1;
    int   rp [$];
    int   rl [$];
    int   rs [$];
    int   re [$];
    int   li;
    int   exp_port [6] = '{0, 1, 0, 1, 0, 1};
    int   exp_len  [6] = '{4, 4, 4, 4, 2, 2};
    int   exp_gap  [5] = '{1, 1, 1, 1, 2};

    // port, words, expected final grant, expected BUSY cycles
    vecs[0] = '{port: 0, nwords: 3, exp_grant: 0, exp_busy: 6};
    vecs[1] = '{port: 1, nwords: 1, exp_grant: 1, exp_busy: 4};
    vecs[2] = '{port: 2, nwords: 4, exp_grant: 2, exp_busy: 6};
    vecs[3] = '{port: 3, nwords: 6, exp_grant: 3, exp_busy: 10};

    rst      = 1'b1;
    out_read = 1'b0;
    refresh();

    repeat (2) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_empty", 32'(out_empty), 32'd1);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_in_read",   32'(in_read),   32'd0);
    chk("rst_grant",     32'(grant),     32'd3);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    out_read = 1'b1;

    // Pops on an empty buffer are ignored.
    repeat (3) step();
    chk("idle_pop_empty", 32'(out_empty), 32'd1);
    chk("idle_pop_count", 32'(dut.u_obuf.count), 32'd0);

    for (int v = 0; v < 4; v++) begin
      clear_ev();
      load(vecs[v].port, vecs[v].nwords);
      push_exp(vecs[v].port, 0, vecs[v].nwords);
      refresh();
      run_to_idle(100, bn);
      chk("vec_reads",       32'(rd_cnt),       32'(vecs[v].nwords));
      chk("vec_busy_cycles", 32'(bn),           32'(vecs[v].exp_busy));
      chk("vec_grant",       32'(grant),        32'(vecs[v].exp_grant));
      chk("vec_out_empty",   32'(out_empty),    32'd1);
      chk("vec_drained",     32'(exp_q.size()), 32'd0);
      k1 = (vecs[v].nwords < int'(MB)) ? vecs[v].nwords : int'(MB);
      if (ev_cyc.size() >= k1)
        chk("vec_consecutive", 32'(ev_cyc[k1-1] - ev_cyc[0]), 32'(k1 - 1));
    end

    // Wrap-around: grant is 3, ports 0 and 3 pending; port 0 must win.
    clear_ev();
    load(0, 2);
    load(3, 2);
    push_exp(0, 0, 2);
    push_exp(3, 0, 2);
    refresh();
    run_to_idle(100, bn);
    if (ev_port.size() > 0) chk("wrap_first_port", 32'(ev_port[0]), 32'd0);
    chk("wrap_reads",   32'(rd_cnt),       32'd4);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure, then a simultaneous push/pop on a full buffer.
    out_read = 1'b0;
    clear_ev();
    load(2, 5);
    push_exp(2, 0, 5);
    refresh();
    repeat (12) step();
    chk("bp_reads",     32'(rd_cnt),             32'd2);
    chk("bp_busy",      32'(busy),               32'd1);
    chk("bp_out_empty", 32'(out_empty),          32'd0);
    chk("bp_count",     32'(dut.u_obuf.count),   32'd2);
    out_read = 1'b1;
    step();
    chk("simul_in_read", 32'(rd_s),              32'h4);
    chk("simul_count",   32'(dut.u_obuf.count),  32'd2);
    run_to_idle(100, bn);
    chk("bp_total_reads", 32'(rd_cnt),           32'd5);
    chk("bp_drained",     32'(exp_q.size()),     32'd0);

    // Reset mid-burst with one buffered word.
    out_read = 1'b0;
    clear_ev();
    load(1, 6);
    push_exp(1, 0, 6);
    refresh();
    for (int k = 0; k < 10 && rd_cnt == 0; k++) step();
    chk("mrst_pre_reads", 32'(rd_cnt),            32'd1);
    chk("mrst_pre_count", 32'(dut.u_obuf.count),  32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_in_read",   32'(in_read),           32'd0);
    chk("mrst_out_empty", 32'(out_empty),         32'd1);
    chk("mrst_out_data",  out_data,               32'd0);
    chk("mrst_busy",      32'(busy),              32'd0);
    chk("mrst_grant",     32'(grant),             32'd3);
    chk("mrst_count",     32'(dut.u_obuf.count),  32'd0);
    repeat (3) begin
      step();
      chk("mrst_no_read", 32'(rd_s), 32'd0);
    end
    chk("mrst_src_left", 32'(src_q[1].size()), 32'd5);
    src_q[1].delete();
    exp_q.delete();
    refresh();
    rst      = 1'b0;
    out_read = 1'b1;
    repeat (2) step();

    // Burst limit: two ports with 10 words each alternate in bursts of 4.
    clear_ev();
    load(0, 10);
    load(1, 10);
    push_exp(0, 0, 4);
    push_exp(1, 0, 4);
    push_exp(0, 4, 4);
    push_exp(1, 4, 4);
    push_exp(0, 8, 2);
    push_exp(1, 8, 2);
    refresh();
    run_to_idle(200, bn);
    chk("burst_reads",   32'(rd_cnt),       32'd20);
    chk("burst_drained", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < ev_cyc.size(); k++) begin
      if (k == 0 || ev_port[k] != ev_port[k-1] || ev_cyc[k] != ev_cyc[k-1] + 1) begin
        rp.push_back(ev_port[k]);
        rl.push_back(1);
        rs.push_back(ev_cyc[k]);
        re.push_back(ev_cyc[k]);
      end else begin
        li     = rl.size() - 1;
        rl[li] = rl[li] + 1;
        re[li] = ev_cyc[k];
      end
    end
    chk("burst_runs", 32'(rp.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < rp.size()) begin
        chk("burst_port", 32'(rp[k]), 32'(exp_port[k]));
        chk("burst_len",  32'(rl[k]), 32'(exp_len[k]));
      end
      if (k < 5 && k + 1 < rp.size())
        chk("burst_gap", 32'(rs[k+1] - re[k] - 1), 32'(exp_gap[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
